// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one external magnitude comparator
// among NREQ requesters. Operands are registered into the comparator, the
// result is registered and returned to the granted requester only.
module cmp_share_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_signed,
    output logic [NREQ-1:0]       rsp_valid,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  rsp_lt,
    output logic                  rsp_eq,
    output logic                  rsp_gt,
    output logic [WIDTH-1:0]      cmp_a,
    output logic [WIDTH-1:0]      cmp_b,
    input  logic                  cmp_lt,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt,
    output logic                  cmp_err
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

    state_t            state;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     win;
    logic              win_found;
    logic              grant_en;
    logic              take;
    logic              flags_onehot;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;

    // Round-robin winner: first valid requester scanning from last_grant+1.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned sum;
            sum = 32'(last_grant) + k;
            if (sum >= NREQ) sum = sum - NREQ;
            if (!win_found && req_valid[IW'(sum)]) begin
                win       = IW'(sum);
                win_found = 1'b1;
            end
        end
    end

    // Winner's operands; MSB inversion maps two's-complement onto unsigned order.
    always_comb begin
        a_sel = req_a[win*WIDTH +: WIDTH];
        b_sel = req_b[win*WIDTH +: WIDTH];
        if (req_signed[win]) begin
            a_sel[WIDTH-1] = ~a_sel[WIDTH-1];
            b_sel[WIDTH-1] = ~b_sel[WIDTH-1];
        end
    end

    // Grant window: IDLE, or the response handshake cycle; suppressed in reset.
    always_comb begin
        grant_en  = rst_n && ((state == IDLE) || ((state == RESP) && rsp_ready[owner]));
        take      = grant_en && win_found;
        req_ready = '0;
        if (take) req_ready[win] = 1'b1;
    end

    // Exactly one flag set <=> odd parity and not all three.
    always_comb begin
        flags_onehot = (cmp_lt ^ cmp_eq ^ cmp_gt) && !(cmp_lt && cmp_eq && cmp_gt);
    end

    // Transaction FSM with registered operands, result and response valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= IW'(NREQ - 1);
            cmp_a      <= '0;
            cmp_b      <= '0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_gt     <= 1'b0;
            rsp_valid  <= '0;
            cmp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        owner      <= win;
                        last_grant <= win;
                        cmp_a      <= a_sel;
                        cmp_b      <= b_sel;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_lt    <= cmp_lt;
                    rsp_eq    <= cmp_eq;
                    rsp_gt    <= cmp_gt;
                    if (!flags_onehot) cmp_err <= 1'b1;
                    rsp_valid <= {{(NREQ-1){1'b0}}, 1'b1} << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        if (take) begin
                            owner      <= win;
                            last_grant <= win;
                            cmp_a      <= a_sel;
                            cmp_b      <= b_sel;
                            state      <= EVAL;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
